// File: rtl/sqrt_arbiter.sv
//------------------------------------------------------------------------
// sqrt_arbiter - round-robin sharing of one sqrt core, with watchdog abort
// Rev 1.0
//------------------------------------------------------------------------
`default_nettype none

module sqrt_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic           clk_i,
  input  logic           reset_ni,
  input  logic [N-1:0]   req_i,
  input  logic [N*W-1:0] radicand_in_i,
  output logic [N-1:0]   grant_o,
  output logic [N-1:0]   done_o,
  output logic [W-1:0]   root_out_o,
  output logic           err_o,
  output logic [W-1:0]   core_radicand_o,
  output logic           core_start_o,
  input  logic [W-1:0]   core_root_i,
  input  logic           core_valid_i
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_RST = IW'(N - 1);
  localparam logic [N-1:0]  ONE_HOT0 = N'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t        state_q;
  logic [IW-1:0] last_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  grant_q;
  logic [N-1:0]  done_q;
  logic [W-1:0]  root_q;
  logic          err_q;
  logic [W-1:0]  core_rad_q;
  logic          core_start_q;

  logic [IW-1:0] winner_d;
  logic          winner_vld_d;
  logic [IW-1:0] cand;

  // First requester strictly after the previous owner, wrapping around.
  always_comb begin
    winner_d     = last_q;
    winner_vld_d = 1'b0;
    cand         = last_q;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last_q) + k) % N);
      if (!winner_vld_d && req_i[cand]) begin
        winner_d     = cand;
        winner_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= ST_IDLE;
      last_q       <= LAST_RST;
      cnt_q        <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      root_q       <= '0;
      err_q        <= 1'b0;
      core_rad_q   <= '0;
      core_start_q <= 1'b0;
    end else begin
      core_start_q <= 1'b0;
      done_q       <= '0;
      case (state_q)
        ST_IDLE: begin
          if (winner_vld_d) begin
            grant_q      <= ONE_HOT0 << winner_d;
            last_q       <= winner_d;
            core_rad_q   <= radicand_in_i[int'(winner_d)*W +: W];
            core_start_q <= 1'b1;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // A result arriving on the final watchdog cycle still wins.
          if (core_valid_i) begin
            root_q  <= core_root_i;
            err_q   <= 1'b0;
            done_q  <= grant_q;
            state_q <= ST_RESP;
          end else if (cnt_q == CNT_LAST) begin
            root_q  <= '0;
            err_q   <= 1'b1;
            done_q  <= grant_q;
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          grant_q <= '0;
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant_o         = grant_q;
  assign done_o          = done_q;
  assign root_out_o      = root_q;
  assign err_o           = err_q;
  assign core_radicand_o = core_rad_q;
  assign core_start_o    = core_start_q;

endmodule

`default_nettype wire
